i2c_srg_mc: RTL and testbench

- Parametrised successor of the I2C receive/transmit shift register.
- Shifts bits MSB-first, counts bits, and flags completed bytes.
- Supports parallel load for transmit.
- Adds a registered address-match FSM: 7- or 10-bit addressing, up to 4 slave addresses (channels), plus an R/W bit capture.
- Sits between the I2C bus front end (bit sampler / start-stop detector) and the slave controller FSM.

---
 rtl/i2c_srg_mc_pkg.sv | 10 +
 rtl/i2c_addr_cmp.sv | 30 +++
 rtl/i2c_srg_mc_svamod.sv | 52 +++++
 rtl/i2c_srg_mc.sv | 125 ++++++++++++
 tb/tb_i2c_srg_mc.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_srg_mc_pkg.sv
// i2c_srg_mc_pkg: shared constants, types and default address table for the I2C shift register
// Contents: I2C_MAX_ADDR, I2C_10B_PREFIX, I2C_ADDRESS, addr_list_t, I2C_ADDR_LIST_DEFAULT, i2c_srg_state_t
package i2c_srg_mc_pkg;
    localparam int I2C_MAX_ADDR = 4;
    localparam logic [4:0] I2C_10B_PREFIX = 5'b11110;
    localparam logic [9:0] I2C_ADDRESS = 10'h02A;
    typedef logic [I2C_MAX_ADDR-1:0][9:0] addr_list_t;
    localparam addr_list_t I2C_ADDR_LIST_DEFAULT = {10'h000, 10'h000, 10'h000, I2C_ADDRESS};
    typedef enum logic [1:0] {S_ADDR1, S_ADDR2, S_DATA} i2c_srg_state_t;
endpackage

// File: rtl/i2c_addr_cmp.sv
// i2c_addr_cmp: parallel address compare with hit vector and lowest-index priority encoder
// Ports: srg (received byte), second (compare low address byte of a 10-bit address),
//        en (per-entry enable), hit (per-entry match), any (some entry matched), idx (lowest match)
module i2c_addr_cmp
    import i2c_srg_mc_pkg::*;
#(
    parameter int ADDR_MODE = 7,
    parameter int NUM_ADDR = 1,
    parameter int IDX_W = 1,
    parameter addr_list_t ADDR_LIST = I2C_ADDR_LIST_DEFAULT
) (
    input  logic [7:0]          srg,
    input  logic                second,
    input  logic [NUM_ADDR-1:0] en,
    output logic [NUM_ADDR-1:0] hit,
    output logic                any,
    output logic [IDX_W-1:0]    idx
);
    always_comb begin
        hit = '0;
        idx = '0;
        for (int i = 0; i < NUM_ADDR; i++)
            hit[i] = en[i] && (second ? srg == ADDR_LIST[i][7:0] :
                               ADDR_MODE == 10 ? srg[7:1] == {I2C_10B_PREFIX, ADDR_LIST[i][9:8]} :
                               srg[7:1] == ADDR_LIST[i][6:0]);
        for (int i = NUM_ADDR - 1; i >= 0; i--)
            if (hit[i]) idx = IDX_W'(i);
    end
    assign any = |hit;
endmodule

// File: rtl/i2c_srg_mc_svamod.sv
// i2c_srg_mc_svamod: checker for i2c_srg_mc ports (X-checks, shift, clear, hold, load and byte_done pulse)
// Ports: every i2c_srg_mc port as an input; IDX_W must match the checked instance
module i2c_srg_mc_svamod #(
    parameter int IDX_W = 1
) (
    input logic             clk,
    input logic             rst,
    input logic             clr_in,
    input logic             next_in,
    input logic             bit_in,
    input logic             load_in,
    input logic [7:0]       data_in,
    input logic             bit_out,
    input logic [7:0]       data_out,
    input logic             byte_done_out,
    input logic             addrok_out,
    input logic             rw_out,
    input logic [IDX_W-1:0] addr_idx_out,
    input logic             gcall_out
);
    logic v, p_clr, p_load, p_next, p_bit, p_bd;
    logic [7:0] p_data, p_srg;

    // previous-cycle inputs/outputs; v marks that they were captured out of reset
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v <= 1'b0;
            {p_clr, p_load, p_next, p_bit, p_bd, p_data, p_srg} <= '0;
        end else begin
            v <= 1'b1;
            {p_clr, p_load, p_next, p_bit, p_bd, p_data, p_srg} <=
                {clr_in, load_in, next_in, bit_in, byte_done_out, data_in, data_out};
        end

    always @(posedge clk)
        if (v && !rst) begin
            assert (!$isunknown({clr_in, next_in, bit_in, load_in, data_in, bit_out, data_out,
                                 byte_done_out, addrok_out, rw_out, addr_idx_out, gcall_out}));
            assert (bit_out == data_out[7]);
            if (p_clr)
                assert (data_out == 8'h00 && !byte_done_out && !addrok_out && !rw_out &&
                        !gcall_out && addr_idx_out == '0);
            else if (p_load)
                assert (data_out == p_data && !byte_done_out);
            else if (p_next)
                assert (data_out == {p_srg[6:0], p_bit});
            else
                assert (data_out == p_srg && !byte_done_out);
            if (p_bd)
                assert (!byte_done_out);
        end
endmodule

// File: rtl/i2c_srg_mc.sv
// i2c_srg_mc: I2C shift register with bit counter, byte flag, parallel load and address-match FSM
// Ports: clk, rst (async, active high), clr_in (START/repeated START), next_in (shift strobe),
//        bit_in, load_in, data_in[7:0] -> bit_out, data_out[7:0], byte_done_out,
//        addrok_out, rw_out, addr_idx_out[IDX_W-1:0], gcall_out
// Macro I2C_SRG_GCALL_EN enables general-call (address byte 8'h00) detection.
module i2c_srg_mc
    import i2c_srg_mc_pkg::*;
#(
    parameter int ADDR_MODE = 7,
    parameter int NUM_ADDR = 1,
    parameter addr_list_t ADDR_LIST = I2C_ADDR_LIST_DEFAULT,
    localparam int IDX_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_in,
    input  logic             next_in,
    input  logic             bit_in,
    input  logic             load_in,
    input  logic [7:0]       data_in,
    output logic             bit_out,
    output logic [7:0]       data_out,
    output logic             byte_done_out,
    output logic             addrok_out,
    output logic             rw_out,
    output logic [IDX_W-1:0] addr_idx_out,
    output logic             gcall_out
);
`ifdef I2C_SRG_GCALL_EN
    localparam bit GCALL_EN = 1'b1;
`else
    localparam bit GCALL_EN = 1'b0;
`endif
    logic [7:0] srg_r;
    logic [2:0] cnt_r;
    logic bd_r, addrok_r, addrok_n, rw_r, rw_n, gcall_r, gcall_n, any_c, second;
    logic [IDX_W-1:0] idx_r, idx_n, idx_c;
    logic [NUM_ADDR-1:0] hit_r, hit_n, hit_c, en;
    i2c_srg_state_t state_r, state_n;

    // the low-byte compare only considers entries whose 10-bit prefix matched
    assign second = state_r == S_ADDR2;
    assign en = second ? hit_r : {NUM_ADDR{1'b1}};

    i2c_addr_cmp #(
        .ADDR_MODE(ADDR_MODE), .NUM_ADDR(NUM_ADDR), .IDX_W(IDX_W), .ADDR_LIST(ADDR_LIST)
    ) u_cmp (
        .srg(srg_r), .second(second), .en(en), .hit(hit_c), .any(any_c), .idx(idx_c)
    );

    always_comb begin
        state_n = state_r;
        addrok_n = addrok_r;
        rw_n = rw_r;
        idx_n = idx_r;
        gcall_n = gcall_r;
        hit_n = hit_r;
        if (bd_r)
            case (state_r)
                S_ADDR1:
                    if (GCALL_EN && srg_r == 8'h00) begin
                        gcall_n = 1'b1;
                        addrok_n = 1'b1;
                        idx_n = '0;
                        state_n = S_DATA;
                    end else if (ADDR_MODE == 10) begin
                        rw_n = srg_r[0];
                        hit_n = hit_c;
                        state_n = any_c ? S_ADDR2 : S_DATA;
                    end else begin
                        addrok_n = any_c;
                        idx_n = idx_c;
                        rw_n = any_c & srg_r[0];
                        state_n = S_DATA;
                    end
                S_ADDR2: begin
                    addrok_n = any_c;
                    idx_n = idx_c;
                    state_n = S_DATA;
                end
                default: ;
            endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            srg_r <= '0;
            cnt_r <= '0;
            bd_r <= 1'b0;
            state_r <= S_ADDR1;
            addrok_r <= 1'b0;
            rw_r <= 1'b0;
            idx_r <= '0;
            gcall_r <= 1'b0;
            hit_r <= '0;
        end else if (clr_in) begin
            srg_r <= '0;
            cnt_r <= '0;
            bd_r <= 1'b0;
            state_r <= S_ADDR1;
            addrok_r <= 1'b0;
            rw_r <= 1'b0;
            idx_r <= '0;
            gcall_r <= 1'b0;
            hit_r <= '0;
        end else begin
            srg_r <= load_in ? data_in : next_in ? {srg_r[6:0], bit_in} : srg_r;
            cnt_r <= load_in ? 3'd0 : cnt_r + 3'(next_in);
            bd_r <= !load_in && next_in && cnt_r == 3'd7;
            state_r <= state_n;
            addrok_r <= addrok_n;
            rw_r <= rw_n;
            idx_r <= idx_n;
            gcall_r <= gcall_n;
            hit_r <= hit_n;
        end

    assign bit_out = srg_r[7];
    assign data_out = srg_r;
    assign byte_done_out = bd_r;
    assign addrok_out = addrok_r;
    assign rw_out = rw_r;
    assign addr_idx_out = idx_r;
    assign gcall_out = gcall_r;
endmodule

// File: tb/tb_i2c_srg_mc.sv
// tb_i2c_srg_mc: randomized and directed bench for a 7-bit and a 10-bit i2c_srg_mc sharing one stimulus
module tb_i2c_srg_mc;
    import i2c_srg_mc_pkg::*;
`ifdef I2C_SRG_GCALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif
    localparam addr_list_t LA = {10'h000, 10'h000, 10'h051, 10'h02A};
    localparam addr_list_t LB = {10'h000, 10'h2C7, 10'h1A5, 10'h2C7};

    logic clk = 1'b0, rst = 1'b0, clr_in = 1'b0, next_in = 1'b0, bit_in = 1'b0, load_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] da, db;
    logic boa, bob, bda, bdb, oka, okb, rwa, rwb, gca, gcb;
    logic [0:0] ia;
    logic [1:0] ib;
    int ncmp = 0, nerr = 0;
    bit chk_en = 1'b0;

    // model: address bytes completed since the last clear (as the FSM sees them), shift register, bit count
    logic [9:0] lst [2][4] = '{'{10'h02A, 10'h051, 10'h000, 10'h000},
                               '{10'h2C7, 10'h1A5, 10'h2C7, 10'h000}};
    int na [2] = '{2, 3};
    int md [2] = '{7, 10};
    logic [7:0] m_srg, m_pb;
    int m_n;
    logic m_bd, m_pend;
    logic [7:0] evq [$];

    always #5 clk = ~clk;

    i2c_srg_mc #(.ADDR_MODE(7), .NUM_ADDR(2), .ADDR_LIST(LA)) dut_a (
        .clk(clk), .rst(rst), .clr_in(clr_in), .next_in(next_in), .bit_in(bit_in), .load_in(load_in),
        .data_in(data_in), .bit_out(boa), .data_out(da), .byte_done_out(bda), .addrok_out(oka),
        .rw_out(rwa), .addr_idx_out(ia), .gcall_out(gca));
    i2c_srg_mc #(.ADDR_MODE(10), .NUM_ADDR(3), .ADDR_LIST(LB)) dut_b (
        .clk(clk), .rst(rst), .clr_in(clr_in), .next_in(next_in), .bit_in(bit_in), .load_in(load_in),
        .data_in(data_in), .bit_out(bob), .data_out(db), .byte_done_out(bdb), .addrok_out(okb),
        .rw_out(rwb), .addr_idx_out(ib), .gcall_out(gcb));
    i2c_srg_mc_svamod #(.IDX_W(1)) sva_a (
        .clk(clk), .rst(rst), .clr_in(clr_in), .next_in(next_in), .bit_in(bit_in), .load_in(load_in),
        .data_in(data_in), .bit_out(boa), .data_out(da), .byte_done_out(bda), .addrok_out(oka),
        .rw_out(rwa), .addr_idx_out(ia), .gcall_out(gca));
    i2c_srg_mc_svamod #(.IDX_W(2)) sva_b (
        .clk(clk), .rst(rst), .clr_in(clr_in), .next_in(next_in), .bit_in(bit_in), .load_in(load_in),
        .data_in(data_in), .bit_out(bob), .data_out(db), .byte_done_out(bdb), .addrok_out(okb),
        .rw_out(rwb), .addr_idx_out(ib), .gcall_out(gcb));

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_srg = 8'h00; m_pb = 8'h00; m_n = 0; m_bd = 1'b0; m_pend = 1'b0;
        evq.delete();
    endtask

    // one clock edge of the model, applied with the inputs the DUTs saw at that edge
    task automatic mdl_edge();
        if (clr_in) mdl_reset();
        else begin
            if (m_pend) evq.push_back(m_pb);
            m_pend = 1'b0;
            m_bd = 1'b0;
            if (load_in) begin
                m_srg = data_in;
                m_n = 0;
            end else if (next_in) begin
                m_srg = {m_srg[6:0], bit_in};
                m_n++;
                if (m_n == 8) begin
                    m_n = 0; m_bd = 1'b1; m_pend = 1'b1; m_pb = m_srg;
                end
            end
        end
    endtask

    // expected address outcome from the first one or two bytes after a clear
    function automatic void ev(input int k, output logic ok, output logic gc, output logic rw, output int idx);
        logic [7:0] b0, b1;
        ok = 1'b0; gc = 1'b0; rw = 1'b0; idx = 0;
        if (evq.size() == 0) return;
        b0 = evq[0];
        b1 = evq.size() > 1 ? evq[1] : 8'h00;
        if (GC && b0 == 8'h00) begin
            ok = 1'b1; gc = 1'b1;
            return;
        end
        rw = b0[0];
        for (int i = na[k] - 1; i >= 0; i--)
            if (md[k] == 7 ? b0[7:1] == lst[k][i][6:0] :
                evq.size() > 1 && b0[7:1] == {5'b11110, lst[k][i][9:8]} && b1 == lst[k][i][7:0]) begin
                ok = 1'b1; idx = i;
            end
    endfunction

    task automatic cmp(input int k, input logic [7:0] d, input logic bo, input logic bd,
                       input logic ok, input logic rw, input logic gc, input int idx);
        logic eok, egc, erw;
        int eidx;
        ev(k, eok, egc, erw, eidx);
        chk($sformatf("d%0d_data", k), int'(d), int'(m_srg));
        chk($sformatf("d%0d_bit_out", k), int'(bo), int'(m_srg[7]));
        chk($sformatf("d%0d_byte_done", k), int'(bd), int'(m_bd));
        chk($sformatf("d%0d_addrok", k), int'(ok), int'(eok));
        chk($sformatf("d%0d_gcall", k), int'(gc), int'(egc));
        if (eok) chk($sformatf("d%0d_idx", k), idx, eidx);
        if (eok && !egc) chk($sformatf("d%0d_rw", k), int'(rw), int'(erw));
    endtask

    always @(negedge clk)
        if (chk_en) begin
            cmp(0, da, boa, bda, oka, rwa, gca, int'(ia));
            cmp(1, db, bob, bdb, okb, rwb, gcb, int'(ib));
        end

    task automatic step(input logic c, input logic l, input logic n, input logic b, input logic [7:0] d);
        clr_in = c; load_in = l; next_in = n; bit_in = b; data_in = d;
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps && $urandom_range(0, 3) == 0) idle();
            step(1'b0, 1'b0, 1'b1, b[i], 8'h00);
        end
    endtask

    task automatic clr();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int pc;
        logic [7:0] pool [10] = '{8'hA3, 8'h54, 8'h40, 8'hF4, 8'hC7, 8'hC6, 8'hF2, 8'hA5, 8'h00, 8'h2A};
        mdl_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data", int'({da, db}), 0);
        chk("rst_flags", int'({boa, bob, bda, bdb, oka, okb, rwa, rwb, gca, gcb}), 0);
        chk("rst_idx", int'({ia, ib}), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        clr();
        send(8'hA3, 1'b0);
        chk("a3_bd_after_8th", int'(bda), 1);
        chk("a3_addrok_not_yet", int'(oka), 0);
        idle();
        chk("a3_bd_one_cycle", int'(bda), 0);
        chk("a3_addrok", int'(oka), 1);
        chk("a3_idx", int'(ia), 1);
        chk("a3_rw", int'(rwa), 1);
        chk("a3_b_miss", int'(okb), 0);
        clr();
        send(8'h40, 1'b0);
        idle();
        chk("40_miss", int'(oka), 0);
        send(8'h54, 1'b0);
        idle();
        chk("54_no_clr_miss", int'(oka), 0);
        clr();
        send(8'h54, 1'b0);
        idle();
        chk("54_addrok", int'(oka), 1);
        chk("54_idx", int'(ia), 0);
        chk("54_rw", int'(rwa), 0);
        clr();
        send(8'hF4, 1'b0);
        idle();
        chk("f4_addrok_wait", int'(okb), 0);
        send(8'hC7, 1'b0);
        idle();
        chk("f4c7_addrok", int'(okb), 1);
        chk("f4c7_lowest_idx", int'(ib), 0);
        clr();
        send(8'hF4, 1'b0);
        send(8'hC6, 1'b0);
        idle();
        chk("f4c6_miss", int'(okb), 0);
        clr();
        send(8'hF2, 1'b0);
        send(8'hA5, 1'b0);
        idle();
        chk("f2a5_addrok", int'(okb), 1);
        chk("f2a5_idx", int'(ib), 1);
        clr();
        send(8'h00, 1'b0);
        idle();
        chk("gcall_a", int'({gca, oka}), GC ? 3 : 0);
        chk("gcall_b", int'({gcb, okb}), GC ? 3 : 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h96);
        chk("load_data", int'(da), 'h96);
        chk("load_bit_out", int'(boa), 1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("load_cnt_restart7", int'(bda), 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("load_cnt_restart8", int'(bda), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        chk("clr_beats_load", int'(da), 0);
        send(8'h54, 1'b0);
        idle();
        chk("pre_rst_addrok", int'(oka), 1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        next_in = 1'b0;
        #2 rst = 1'b1;
        mdl_reset();
        #1;
        chk("midrst_data", int'(da), 0);
        chk("midrst_flags", int'({boa, bda, oka, rwa, gca, ia}), 0);
        @(negedge clk);
        rst = 1'b0;
        pc = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 1'b0, i < 8, 1'b1, 8'h00);
            if (bda) pc++;
        end
        chk("midrst_one_byte_done", pc, 1);
        for (int t = 0; t < 400; t++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r == 0) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            else if (r == 1) step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
            else if (r == 2) send(8'($urandom), 1'b1);
            else send(pool[$urandom_range(0, 9)], 1'b1);
        end
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
